// File: rtl/feinv.sv
// rtl/feinv.sv - GF(2^255-19) inverse by Fermat exponentiation a^(p-2), driving one femul.
// Optional zero-operand flag output under FEINV_ZERO_FLAG_EN.

module femul (
  input  logic         clk_i,
  input  logic         start_i,
  input  logic [254:0] a_i,
  input  logic [254:0] b_i,
  output logic         done_o,
  output logic [254:0] out_o
);
  localparam logic [255:0] P = {1'b0, 255'h7fffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffed};

  logic [509:0] prod;
  logic [259:0] t1;
  logic [255:0] t2;
  logic         done_q;
  logic [254:0] out_q;

  // 2^255 == 19 mod p: fold the high half twice, then one conditional subtract
  always_comb begin
    prod = 510'(a_i) * 510'(b_i);
    t1   = {5'b0, prod[254:0]} + 260'(prod[509:255]) * 260'd19;
    t2   = {1'b0, t1[254:0]} + 256'(t1[259:255]) * 256'd19;
  end

  always_ff @(posedge clk_i) begin
    done_q <= start_i;
    if (start_i) out_q <= (t2 >= P) ? 255'(t2 - P) : t2[254:0];
  end

  assign done_o = done_q;
  assign out_o  = out_q;
endmodule

module feinv #(
  parameter int EXP_BITS = 255
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         start_i,
  input  logic [254:0] a_i,
  output logic         busy_o,
  output logic         done_o,
  output logic [254:0] out_o
`ifdef FEINV_ZERO_FLAG_EN
  ,
  output logic         zero_o
`endif
);
  localparam logic [254:0] EXP = {{(EXP_BITS-5){1'b1}}, 5'b01011};

  typedef enum logic [2:0] {IDLE, SQ_ISSUE, SQ_WAIT, MU_ISSUE, MU_WAIT, FIN} state_t;

  state_t       state_q;
  logic [7:0]   i_q;
  logic [254:0] r_q, a_q, out_q;
  logic         busy_q, done_q, flush_q, mul_start_q;
  logic         mul_done, accept;
  logic [254:0] mul_b, mul_out;

  assign accept = (state_q == IDLE) && start_i && !flush_q;
  assign mul_b  = (state_q == MU_ISSUE || state_q == MU_WAIT) ? a_q : r_q;

  femul u_mul (
    .clk_i  (clk_i),
    .start_i(mul_start_q),
    .a_i    (r_q),
    .b_i    (mul_b),
    .done_o (mul_done),
    .out_o  (mul_out)
  );

  // The per-bit "next" step is folded into the completion cycle of each wait state
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      i_q         <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      out_q       <= '0;
      mul_start_q <= 1'b0;
      flush_q     <= (flush_q || state_q == SQ_WAIT || state_q == MU_WAIT) && !mul_done;
    end else begin
      done_q      <= 1'b0;
      mul_start_q <= 1'b0;
      if (mul_done) flush_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            a_q     <= a_i;
            r_q     <= a_i;
            i_q     <= 8'(EXP_BITS - 2);
            busy_q  <= 1'b1;
            state_q <= SQ_ISSUE;
          end
        end
        SQ_ISSUE: begin
          mul_start_q <= 1'b1;
          state_q     <= SQ_WAIT;
        end
        SQ_WAIT: begin
          if (mul_done) begin
            r_q <= mul_out;
            if (EXP[i_q]) state_q <= MU_ISSUE;
            else if (i_q == 8'd0) state_q <= FIN;
            else begin
              i_q     <= i_q - 8'd1;
              state_q <= SQ_ISSUE;
            end
          end
        end
        MU_ISSUE: begin
          mul_start_q <= 1'b1;
          state_q     <= MU_WAIT;
        end
        MU_WAIT: begin
          if (mul_done) begin
            r_q <= mul_out;
            if (i_q == 8'd0) state_q <= FIN;
            else begin
              i_q     <= i_q - 8'd1;
              state_q <= SQ_ISSUE;
            end
          end
        end
        FIN: begin
          out_q   <= r_q;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy_o = busy_q | flush_q;
  assign done_o = done_q;
  assign out_o  = out_q;

`ifdef FEINV_ZERO_FLAG_EN
  localparam logic [254:0] P255 = 255'h7fffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffed;
  logic a_zero_q, zero_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      a_zero_q <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      if (accept) a_zero_q <= (a_i == '0) || (a_i == P255);
      if (state_q == FIN) zero_q <= a_zero_q;
    end
  end

  assign zero_o = zero_q;
`endif
endmodule

// File: tb/tb_feinv.sv
// tb/tb_feinv.sv - randomized bench for feinv against a modular-exponent reference model.
module tb_feinv;
  localparam int L    = 1;
  localparam int OP   = L + 2;
  localparam int NOPS = 506;
  localparam int LAT  = NOPS * OP + 2;
  localparam logic [254:0] P    = 255'h7fffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffed;
  localparam logic [254:0] PM1  = 255'h7fffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffec;
  localparam logic [254:0] H2   = 255'h3fffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_fffffff7;
  localparam logic [254:0] BIG  = 255'h6483b328_0badf00d_12345678_9abcdef0_0fedcba9_87654321_deadbeef_cafe20de;
  localparam logic [254:0] ONES = '1;

  logic         clk = 1'b0;
  logic         reset_i = 1'b1;
  logic         start_i = 1'b0;
  logic [254:0] a_i = '0;
  logic         busy_o, done_o;
  logic [254:0] out_o;
`ifdef FEINV_ZERO_FLAG_EN
  logic         zero_o;
`endif

  always #5 clk = ~clk;

  feinv dut (
    .clk_i  (clk),
    .reset_i(reset_i),
    .start_i(start_i),
    .a_i    (a_i),
    .busy_o (busy_o),
    .done_o (done_o),
    .out_o  (out_o)
`ifdef FEINV_ZERO_FLAG_EN
    ,
    .zero_o (zero_o)
`endif
  );

  int n_cmp = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [254:0] act, input logic [254:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [254:0] mmul(input logic [254:0] x, input logic [254:0] y);
    logic [511:0] t;
    t = 512'(x) * 512'(y);
    return 255'(t % 512'(P));
  endfunction

  // right-to-left exponentiation by p-2
  function automatic logic [254:0] finv(input logic [254:0] x);
    logic [254:0] r, b, e;
    r = 255'd1;
    b = x % P;
    e = P - 255'd2;
    for (int k = 0; k < 255; k++) begin
      if (e[k]) r = mmul(r, b);
      b = mmul(b, b);
    end
    return r;
  endfunction

  function automatic logic [254:0] rnd255();
    logic [255:0] t;
    t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    return t[254:0];
  endfunction

  bit           m_active = 1'b0;
  int           m_d = 0;
  logic [254:0] m_res = '0;
  logic [254:0] m_out = '0;
  bit           m_done = 1'b0;
  int           m_flush = 0;
  bit           m_zero = 1'b0;
  bit           m_rzero = 1'b0;

  // Reference: each op occupies OP cycles (issue, start, done); reset while a product is in flight
  // leaves busy high until that product comes back.
  initial begin
    int fl, ph;
    bit acc;
    forever begin
      @(posedge clk);
      if (reset_i) begin
        fl = (m_flush > 1) ? m_flush - 1 : 0;
        if (m_active && m_d >= 1 && m_d <= NOPS * OP) begin
          ph = (m_d - 1) % OP;
          if (ph >= 1 && ph <= OP - 2 && OP - 1 - ph > fl) fl = OP - 1 - ph;
        end
        m_active = 1'b0;
        m_out    = '0;
        m_done   = 1'b0;
        m_zero   = 1'b0;
        m_flush  = fl;
      end else begin
        acc    = !m_active && m_flush == 0 && start_i;
        m_done = 1'b0;
        if (m_flush > 0) m_flush--;
        if (m_active) begin
          m_d++;
          if (m_d == LAT) begin
            m_done   = 1'b1;
            m_out    = m_res;
            m_zero   = m_rzero;
            m_active = 1'b0;
          end
        end else if (acc) begin
          m_active = 1'b1;
          m_d      = 1;
          m_res    = finv(a_i);
          m_rzero  = (a_i % P) == '0;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("done", 255'(done_o), 255'(m_done));
        check("busy", 255'(busy_o), 255'(m_active || m_flush > 0));
        check("out", out_o, m_out);
`ifdef FEINV_ZERO_FLAG_EN
        check("zero", 255'(zero_o), 255'(m_zero));
`endif
      end
    end
  end

  // intr > 0: pulse a stray start that many cycles into the operation
  task automatic run_op(input logic [254:0] a, input int intr, output int lat);
    @(negedge clk);
    a_i = a;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    a_i = rnd255();
    lat = 1;
    while (!done_o && lat < LAT + 50) begin
      start_i = (lat == intr);
      @(negedge clk);
      start_i = 1'b0;
      lat++;
    end
    if (!done_o) begin
      n_cmp++;
      n_fail++;
      $display("FAIL timeout: no done after %0d cycles, required %0d", lat, LAT);
    end
  endtask

  initial begin
    int lat;
    logic [254:0] ra;
    repeat (3) @(negedge clk);
    check("rst_busy", 255'(busy_o), 255'd0);
    check("rst_done", 255'(done_o), 255'd0);
    check("rst_out", out_o, 255'd0);
    chk_en = 1'b1;
    reset_i = 1'b0;

    check("model_inv1", finv(255'd1), 255'd1);
    check("model_inv2", finv(255'd2), H2);
    check("model_h2x2", mmul(H2, 255'd2), 255'd1);

    run_op(255'd1, 0, lat);
    check("lat_a1", 255'(lat), 255'd1520);
    check("inv_1", out_o, 255'd1);
    check("busy_at_done", 255'(busy_o), 255'd0);

    run_op(255'd2, 0, lat);
    check("inv_2", out_o, H2);

    @(negedge clk);
    reset_i = 1'b1;
    start_i = 1'b1;
    a_i = 255'd5;
    @(negedge clk);
    reset_i = 1'b0;
    start_i = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_start_drop", 255'(busy_o), 255'd0);

    run_op(PM1, 0, lat);
    check("inv_pm1", out_o, PM1);
    run_op(ONES, 0, lat);
    check("ones_times_inv", mmul(ONES, out_o), 255'd1);

    run_op(255'd0, 0, lat);
    check("inv_0", out_o, 255'd0);
`ifdef FEINV_ZERO_FLAG_EN
    check("zero_a0", 255'(zero_o), 255'd1);
`endif
    run_op(P, 0, lat);
    check("inv_p", out_o, 255'd0);
`ifdef FEINV_ZERO_FLAG_EN
    check("zero_ap", 255'(zero_o), 255'd1);
    run_op(255'd5, 0, lat);
    check("zero_a5", 255'(zero_o), 255'd0);
`endif

    run_op(255'd1, 700, lat);
    check("stray_start", out_o, 255'd1);
    run_op(BIG, 0, lat);
    check("lat_big", 255'(lat), 255'd1520);

    @(negedge clk);
    a_i = 255'd9;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    @(negedge clk);
    reset_i = 1'b1;
    @(negedge clk);
    reset_i = 1'b0;
    check("flush_busy", 255'(busy_o), 255'd1);
    check("flush_out", out_o, 255'd0);
    a_i = 255'd3;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    check("flush_start_drop", 255'(busy_o), 255'd0);
    run_op(255'd2, 0, lat);
    check("after_flush_inv2", out_o, H2);

    for (int n = 0; n < 5; n++) begin
      ra = rnd255();
      @(negedge clk);
      a_i = ra;
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      repeat ($urandom_range(0, 40)) @(negedge clk);
      reset_i = 1'b1;
      @(negedge clk);
      reset_i = 1'b0;
      start_i = $urandom_range(0, 1) == 1;
      @(negedge clk);
      start_i = 1'b0;
      repeat (3) @(negedge clk);
      run_op(rnd255(), (n % 2 == 0) ? int'($urandom_range(1, 1500)) : 0, lat);
      check("lat_rand", 255'(lat), 255'd1520);
    end

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/feinv.md
Name: feinv

Overview:
- Sequential inverter over GF(2^255-19). Computes out = a^(p-2) mod p, with p = 2^255-19.
- Acts as the initiator side of the femul start/done handshake. It instantiates one femul and drives it through a left-to-right square-and-multiply loop.
- Sits beside femul in the curve25519 datapath. Typical use: converting projective coordinates to affine.

Parameters:
- EXP_BITS, 255, exponent width; the exponent is the fixed constant p-2 = 2^255-21.

Ports:
- clock  in  1  rising-edge clock shared with the internal femul.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle request; a is sampled in the same cycle.
- a  in  255  operand; any value in [0, 2^255). Non-canonical values are allowed.
- busy  out  1  high from the cycle after start is accepted until done; also high while flushing.
- done  out  1  one-cycle pulse; out is valid in the same cycle.
- out  out  255  canonical result in [0, p); held until the next accepted start.

Behaviour:
- Reset values: busy=0, done=0, out=0, state=IDLE, flush=0.
- Exponent p-2 bit pattern:
  - bit 254 = 1.
  - bits 253..5 are all 1.
  - bits 4..0 = 01011.
- States and transitions:
  - IDLE: start && !flush → latch a into a_reg, set r=a (this consumes bit 254), set i=253, go to SQ_ISSUE. start while busy is ignored.
  - SQ_ISSUE: pulse mul_start for one cycle with operands (r, r), go to SQ_WAIT.
  - SQ_WAIT: on femul done, r <= product. If e[i]=1 go to MU_ISSUE; else go to NEXT.
  - MU_ISSUE: pulse mul_start with operands (r, a_reg), go to MU_WAIT.
  - MU_WAIT: on femul done, r <= product, go to NEXT.
  - NEXT: if i==0, go to FIN; else i <= i-1, go to SQ_ISSUE.
  - FIN: out <= r, done=1 for exactly one cycle, busy=0, go to IDLE.
- Operation count: 254 squarings + 252 multiplications = 506 femul operations.
- Latency: let L be femul's start-to-done latency. Start-to-done latency is fixed at 506*(L+2) + 2 cycles, independent of a.
- Handshake with femul:
  - mul_start is high for a single cycle only.
  - Both operands are held stable from issue until femul done.
  - Exactly one femul operation is outstanding at any time.
- Index i: 8-bit counter; it never wraps below 0.
- Zero inputs: a=0 and a=p both yield out=0; no special-casing is needed.
- Reset mid-operation:
  - FSM returns to IDLE; outputs take their reset values.
  - If a femul operation was outstanding (state SQ_WAIT or MU_WAIT), set flush=1 and busy=1.
  - The next femul done is discarded and clears flush.
  - start is ignored while flush=1.
  - femul itself has no reset.
- Simultaneous reset and start: reset wins; start is dropped.
- Simultaneous femul done and reset: counts as the drained completion; flush stays 0.

Optional Feature:
- Macro FEINV_ZERO_FLAG_EN.
- Defined:
  - Adds output port zero (1 bit, reset 0).
  - zero is set with done when a_reg ≡ 0 mod p, i.e. a==0 or a==0x7fff...ffed.
  - zero holds with out until the next start.
  - Compare is registered at start acceptance; latency is unchanged.
- Undefined: no zero port and no compare logic.

Test Plan:
- a=1 → done after the fixed latency; out=1; busy drops the same cycle done rises.
- a=2 → out = 0x3fff...fff7 (2^254-9). Reset with start asserted in the same cycle → no operation starts.
- a = 0x7fff...ffec (p-1) → out = 0x7fff...ffec. a=2^255-1 (non-canonical 18) → femul(a, out) equals 1.
- a=0 and a=p → out=0 both times. With FEINV_ZERO_FLAG_EN, zero=1; for a=5, zero=0.
- Back-to-back requests:
  - start pulsed mid-operation is ignored and the result is unchanged.
  - New start the cycle after done is accepted.
  - Measured latency identical for a=1 and a = 0x6483b328...20de.
- Reset asserted while in SQ_WAIT:
  - outputs return to 0 and busy=1 (flush).
  - start issued before the stale femul done is ignored.
  - start issued after the stale femul done, with a=2, yields 0x3fff...fff7.
